// File: rtl/vend_ctrl_fsm.sv
// Vending controller: nickel/dime credit tracking toward a 25c price,
// timed dispense pulse, and change/refund returned as nickel pulses.
// Also holds the credit-range checker used by the controller.

// Simulation checker: accumulated credit must fit the 3-bit credit range.
module vend_ctrl_fsm_chk (
  input logic       clk,
  input logic       reset,
  input logic [3:0] credit_sum_s
);

  // Flag any credit accumulation that would not fit in 3 bits
  always @(posedge clk) begin
    if (!reset) begin
      assert (credit_sum_s <= 4'd7)
        else $error("credit overflow: %0d", credit_sum_s);
    end
  end

endmodule

module vend_ctrl_fsm #(
  parameter int VEND_CYCLES = 4,
  parameter int PULSE_GAP   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_n,
  input  logic       coin_d,
  input  logic       cancel,
  output logic [3:0] State,
  output logic [2:0] credit,
  output logic       dispense,
  output logic       change_pulse,
  output logic       coin_reject
);

  localparam int TW = 8;
  localparam logic [TW-1:0] VEND_LAST_C = TW'(VEND_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST_C  = TW'(PULSE_GAP - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_C5     = 4'd1,
    S_C10    = 4'd2,
    S_C15    = 4'd3,
    S_C20    = 4'd4,
    S_PAID   = 4'd5,
    S_VEND   = 4'd6,
    S_CHANGE = 4'd7,
    S_CANCEL = 4'd8
  } state_t;

  state_t        state_r, state_nx_s;
  logic [2:0]    credit_r, credit_nx_s;
  logic [TW-1:0] timer_r, timer_nx_s;
  logic          dispense_r, dispense_nx_s;
  logic          pulse_r, pulse_nx_s;
  logic          reject_r, reject_nx_s;
  logic          n_q_r, d_q_r, c_q_r;
  logic          n_edge_s, d_edge_s, c_edge_s;
  logic          accepting_s;
  logic [3:0]    sum_s;
  logic [3:0]    chk_sum_s;

  assign n_edge_s    = coin_n & ~n_q_r;
  assign d_edge_s    = coin_d & ~d_q_r;
  assign c_edge_s    = cancel & ~c_q_r;
  assign accepting_s = (state_r <= S_C20);
  assign sum_s       = {1'b0, credit_r} + {3'b000, n_edge_s} + {2'b00, d_edge_s, 1'b0};
  assign chk_sum_s   = accepting_s ? sum_s : {1'b0, credit_r};

  // Edge-detect history; reset high so levels held through reset are not edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q_r <= 1'b1;
      d_q_r <= 1'b1;
      c_q_r <= 1'b1;
    end else begin
      n_q_r <= coin_n;
      d_q_r <= coin_d;
      c_q_r <= cancel;
    end
  end

  // State, credit, timer and registered (Moore) outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      credit_r   <= 3'd0;
      timer_r    <= '0;
      dispense_r <= 1'b0;
      pulse_r    <= 1'b0;
      reject_r   <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      credit_r   <= credit_nx_s;
      timer_r    <= timer_nx_s;
      dispense_r <= dispense_nx_s;
      pulse_r    <= pulse_nx_s;
      reject_r   <= reject_nx_s;
    end
  end

  // Next-state, credit bookkeeping and next output values
  always_comb begin
    state_nx_s    = state_r;
    credit_nx_s   = credit_r;
    timer_nx_s    = timer_r;
    dispense_nx_s = 1'b0;
    pulse_nx_s    = 1'b0;
    reject_nx_s   = 1'b0;

    // Coins arriving while not accepting are refused, one pulse per cycle
    if (!accepting_s && (n_edge_s || d_edge_s)) begin
      reject_nx_s = 1'b1;
    end else begin
      reject_nx_s = 1'b0;
    end

    case (state_r)
      S_IDLE, S_C5, S_C10, S_C15, S_C20: begin
        credit_nx_s = sum_s[2:0];
        timer_nx_s  = '0;
        if (c_edge_s && (state_r != S_IDLE)) begin
          // Same-cycle coins are credited first, then everything is refunded
          state_nx_s = S_CANCEL;
          pulse_nx_s = 1'b1;
        end else if (sum_s >= 4'd5) begin
          state_nx_s = S_PAID;
        end else begin
          state_nx_s = state_t'(sum_s);
        end
      end
      S_PAID: begin
        credit_nx_s   = credit_r - 3'd5;
        state_nx_s    = S_VEND;
        timer_nx_s    = '0;
        dispense_nx_s = 1'b1;
      end
      S_VEND: begin
        if (timer_r >= VEND_LAST_C) begin
          timer_nx_s = '0;
          if (credit_r != 3'd0) begin
            state_nx_s = S_CHANGE;
            pulse_nx_s = 1'b1;
          end else begin
            state_nx_s = S_IDLE;
          end
        end else begin
          timer_nx_s    = timer_r + 8'd1;
          dispense_nx_s = 1'b1;
        end
      end
      S_CHANGE, S_CANCEL: begin
        if (pulse_r) begin
          // One nickel leaves on the edge that ends the pulse
          credit_nx_s = credit_r - 3'd1;
          timer_nx_s  = '0;
        end else if (timer_r >= GAP_LAST_C) begin
          timer_nx_s = '0;
          if (credit_r == 3'd0) begin
            state_nx_s = S_IDLE;
          end else begin
            pulse_nx_s = 1'b1;
          end
        end else begin
          timer_nx_s = timer_r + 8'd1;
        end
      end
      default: begin
        state_nx_s  = S_IDLE;
        credit_nx_s = 3'd0;
        timer_nx_s  = '0;
      end
    endcase
  end

  assign State        = state_r;
  assign credit       = credit_r;
  assign dispense     = dispense_r;
  assign change_pulse = pulse_r;
  assign coin_reject  = reject_r;

  vend_ctrl_fsm_chk u_chk (
    .clk          (clk),
    .reset        (reset),
    .credit_sum_s (chk_sum_s)
  );

endmodule

// File: tb/tb_vend_ctrl_fsm.sv
// Directed self-checking bench for vend_ctrl_fsm.
module tb_vend_ctrl_fsm;

  logic       clk;
  logic       reset;
  logic       coin_n;
  logic       coin_d;
  logic       cancel;
  logic [3:0] State;
  logic [2:0] credit;
  logic       dispense;
  logic       change_pulse;
  logic       coin_reject;

  int checks;
  int failures;
  int disp_cnt;
  int pulse_cnt;
  logic [7:0] pat;

  vend_ctrl_fsm #(.VEND_CYCLES(4), .PULSE_GAP(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .coin_n       (coin_n),
    .coin_d       (coin_d),
    .cancel       (cancel),
    .State        (State),
    .credit       (credit),
    .dispense     (dispense),
    .change_pulse (change_pulse),
    .coin_reject  (coin_reject)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Set input levels and advance one clock
  task automatic drive(input logic n, input logic d, input logic c);
    coin_n = n;
    coin_d = d;
    cancel = c;
    tick(1);
  endtask

  // Drop all input levels and advance one clock
  task automatic release_in();
    coin_n = 1'b0;
    coin_d = 1'b0;
    cancel = 1'b0;
    tick(1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    coin_n   = 1'b1;
    coin_d   = 1'b0;
    cancel   = 1'b0;
    tick(2);
    chk("rst_state", State, 0);
    chk("rst_credit", credit, 0);
    chk("rst_dispense", dispense, 0);
    chk("rst_pulse", change_pulse, 0);
    chk("rst_reject", coin_reject, 0);

    // Nickel held high through reset must not count
    reset = 1'b0;
    tick(2);
    chk("held_nickel_state", State, 0);
    chk("held_nickel_credit", credit, 0);
    release_in();

    // Five nickels: 1,2,3,4,PAID then VEND for 4 cycles, no change
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      chk("nickel_state", State, i);
      chk("nickel_credit", credit, i);
      release_in();
    end
    drive(1'b1, 1'b0, 1'b0);
    chk("n5_paid", State, 5);
    chk("n5_paid_credit", credit, 5);
    release_in();
    chk("n5_vend", State, 6);
    chk("n5_vend_credit", credit, 0);
    disp_cnt  = int'(dispense);
    pulse_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      disp_cnt  += int'(dispense);
      pulse_cnt += int'(change_pulse);
    end
    chk("n5_dispense_cycles", disp_cnt, 4);
    chk("n5_change_pulses", pulse_cnt, 0);
    chk("n5_end_state", State, 0);

    // Cancel in IDLE is ignored
    drive(1'b0, 1'b0, 1'b1);
    chk("idle_cancel_state", State, 0);
    release_in();

    // dime, dime, nickel: 2,4,PAID,VEND, credit 0, no change
    drive(1'b0, 1'b1, 1'b0);
    chk("ddn_s2", State, 2);
    release_in();
    drive(1'b0, 1'b1, 1'b0);
    chk("ddn_s4", State, 4);
    release_in();
    drive(1'b1, 1'b0, 1'b0);
    chk("ddn_paid", State, 5);
    release_in();
    chk("ddn_vend", State, 6);
    chk("ddn_vend_credit", credit, 0);
    pulse_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      pulse_cnt += int'(change_pulse);
    end
    chk("ddn_pulses", pulse_cnt, 0);
    chk("ddn_end_state", State, 0);

    // C20 then dime: PAID, VEND, CHANGE with one pulse, IDLE
    drive(1'b0, 1'b1, 1'b0);
    release_in();
    drive(1'b0, 1'b1, 1'b0);
    release_in();
    chk("c20_state", State, 4);
    drive(1'b0, 1'b1, 1'b0);
    chk("c20d_paid", State, 5);
    chk("c20d_paid_credit", credit, 6);
    release_in();
    chk("c20d_vend_credit", credit, 1);
    tick(3);
    chk("c20d_still_vend", State, 6);
    tick(1);
    chk("c20d_change", State, 7);
    chk("c20d_pulse", change_pulse, 1);
    tick(1);
    chk("c20d_gap_pulse", change_pulse, 0);
    chk("c20d_credit_done", credit, 0);
    tick(1);
    chk("c20d_idle", State, 0);

    // C20 then nickel+dime together: credit 7, two change pulses 2 cycles apart
    drive(1'b0, 1'b1, 1'b0);
    release_in();
    drive(1'b0, 1'b1, 1'b0);
    release_in();
    drive(1'b1, 1'b1, 1'b0);
    chk("both_paid", State, 5);
    chk("both_credit7", credit, 7);
    release_in();
    chk("both_vend_credit", credit, 2);
    tick(3);
    pat = 8'd0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      pat[k] = change_pulse;
    end
    chk("both_pulse_pattern", int'(pat), 8'b0000_0101);
    chk("both_end_state", State, 0);
    chk("both_end_credit", credit, 0);

    // C15 then cancel: CANCEL, 3 pulses with gap 1, credit 3->0, IDLE
    drive(1'b0, 1'b1, 1'b0);
    release_in();
    drive(1'b1, 1'b0, 1'b0);
    release_in();
    chk("c15_state", State, 3);
    drive(1'b0, 1'b0, 1'b1);
    chk("cancel_state", State, 8);
    chk("cancel_credit", credit, 3);
    pat    = 8'd0;
    pat[0] = change_pulse;
    release_in();
    pat[1] = change_pulse;
    chk("cancel_credit_after1", credit, 2);
    for (int k = 2; k < 6; k++) begin
      tick(1);
      pat[k] = change_pulse;
    end
    chk("cancel_pulse_pattern", int'(pat), 8'b0001_0101);
    chk("cancel_credit_zero", credit, 0);
    tick(1);
    chk("cancel_idle", State, 0);

    // Dime during VEND is rejected, credit unchanged; then reset in VEND
    drive(1'b0, 1'b1, 1'b0);
    release_in();
    drive(1'b0, 1'b1, 1'b0);
    release_in();
    drive(1'b1, 1'b0, 1'b0);
    release_in();
    chk("rej_vend", State, 6);
    drive(1'b0, 1'b1, 1'b0);
    chk("rej_pulse", coin_reject, 1);
    chk("rej_credit", credit, 0);
    chk("rej_state", State, 6);
    release_in();
    chk("rej_pulse_gone", coin_reject, 0);
    chk("rej_dispense_on", dispense, 1);
    reset = 1'b1;
    #1;
    chk("async_rst_state", State, 0);
    chk("async_rst_dispense", dispense, 0);
    chk("async_rst_credit", credit, 0);
    tick(1);
    reset = 1'b0;
    tick(2);
    chk("post_rst_state", State, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
